// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stall bus, jump flush sequencing, stall watchdog.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs2_re_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_stallreq_i,
  input  logic             mem_stallreq_i,
  input  logic             jump_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT - 1);
  localparam logic [2:0] F_RELOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic MULTI_FLUSH     = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  state_e          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
  logic            load_use_s;
  logic            jump_ok_s;
  logic            flush_s;
  logic [5:0]      stall_s;

  // Hazard detection and stall/flush priority encoding
  always_comb begin
    load_use_s = ex_is_load_i && (ex_rd_i != 5'd0) &&
                 ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                  (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
    // a jump only leaves EXE once exe_mem is no longer held
    jump_ok_s  = jump_i && !(mem_stallreq_i || ex_stallreq_i);
    flush_s    = 1'b0;
    stall_s    = 6'b000000;
    if (rst_i) begin
      flush_s = 1'b0;
      stall_s = 6'b000000;
    end else begin
      flush_s = jump_ok_s || (state_q == ST_FLUSH);
      if (mem_stallreq_i) begin
        stall_s = 6'b011111;
      end else if (ex_stallreq_i) begin
        stall_s = 6'b001111;
      end else if (load_use_s && !flush_s) begin
        stall_s = 6'b000111;
      end else begin
        stall_s = 6'b000000;
      end
    end
  end

  assign stall_o         = stall_s;
  assign flush_o         = flush_s;
  assign stall_timeout_o = timeout_q;

  // Flush sequencer next state
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (jump_ok_s && MULTI_FLUSH) begin
          state_d = ST_FLUSH;
          fcnt_d  = F_RELOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (jump_ok_s) begin
          fcnt_d = F_RELOAD;
        end else if (!stall_s[1]) begin
          if (fcnt_q <= 3'd1) begin
            state_d = ST_RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  // Stall watchdog: saturating run-length counter with sticky flag
  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (stall_s[0]) begin
      if (tcnt_q != T_MAX) begin
        tcnt_d = tcnt_q + TW'(1);
      end else begin
        tcnt_d    = tcnt_q;
        timeout_d = 1'b1;
      end
    end else begin
      tcnt_d = {TW{1'b0}};
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      fcnt_q    <= 3'd0;
      tcnt_q    <= {TW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Performance counter increments (wrap naturally)
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_s[0]) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (stall_s == 6'b000111) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = {CNT_W{1'b0}};
  assign bubble_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with single-cycle flush, one with 3-cycle flush.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        rs1_re, rs2_re, ex_load, ex_stall, mem_stall, jump;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, to_a, to_b;
  logic [31:0] sc_a, bc_a, sc_b, bc_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(rs1), .id_rs1_re_i(rs1_re), .id_rs2_i(rs2), .id_rs2_re_i(rs2_re),
    .ex_is_load_i(ex_load), .ex_rd_i(ex_rd), .ex_stallreq_i(ex_stall),
    .mem_stallreq_i(mem_stall), .jump_i(jump),
    .stall_o(stall_a), .flush_o(flush_a), .stall_timeout_o(to_a),
    .stall_cnt_o(sc_a), .bubble_cnt_o(bc_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(rs1), .id_rs1_re_i(rs1_re), .id_rs2_i(rs2), .id_rs2_re_i(rs2_re),
    .ex_is_load_i(ex_load), .ex_rd_i(ex_rd), .ex_stallreq_i(ex_stall),
    .mem_stallreq_i(mem_stall), .jump_i(jump),
    .stall_o(stall_b), .flush_o(flush_b), .stall_timeout_o(to_b),
    .stall_cnt_o(sc_b), .bubble_cnt_o(bc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lu(input logic on);
    ex_load = on;
    ex_rd   = 5'd5;
    rs2_re  = on;
    rs2     = 5'd5;
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    rs1_re = 1'b0; rs2_re = 1'b0; ex_load = 1'b0;
    ex_stall = 1'b0; mem_stall = 1'b0; jump = 1'b0;

    // outputs gated while reset is high
    mem_stall = 1'b1; jump = 1'b1;
    step();
    @(negedge clk);
    check("rst_stall_a", 32'(stall_a), 32'h00);
    check("rst_flush_a", 32'(flush_a), 32'h0);
    check("rst_flush_b", 32'(flush_b), 32'h0);
    check("rst_to_a", 32'(to_a), 32'h0);
    mem_stall = 1'b0; jump = 1'b0;
    step();
    rst = 1'b0;

    // load-use on rs2
    lu(1'b1);
    @(negedge clk);
    check("lu_stall_a", 32'(stall_a), 32'h07);
    check("lu_flush_a", 32'(flush_a), 32'h0);
    check("lu_stall_b", 32'(stall_b), 32'h07);
    step();
`ifdef PIPE_CTRL_PERF_EN
    check("lu_bubble_cnt", bc_a, 32'd1);
    check("lu_stall_cnt", sc_a, 32'd1);
`else
    check("lu_bubble_cnt_off", bc_a, 32'd0);
    check("lu_stall_cnt_off", sc_a, 32'd0);
`endif
    // x0 never triggers
    ex_rd = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    check("lu_x0", 32'(stall_a), 32'h00);
    step();
    // rs1 match, then rs1 match without read enable
    lu(1'b0); ex_load = 1'b1; ex_rd = 5'd7; rs1 = 5'd7; rs1_re = 1'b1;
    @(negedge clk);
    check("lu_rs1", 32'(stall_a), 32'h07);
    step();
    rs1_re = 1'b0;
    @(negedge clk);
    check("lu_rs1_nore", 32'(stall_a), 32'h00);
    step();
    ex_load = 1'b0; rs1 = 5'd0;

    // priority
    lu(1'b1); mem_stall = 1'b1; ex_stall = 1'b1;
    @(negedge clk);
    check("prio_mem", 32'(stall_a), 32'h1f);
    step();
    mem_stall = 1'b0;
    @(negedge clk);
    check("prio_ex", 32'(stall_a), 32'h0f);
    step();
    ex_stall = 1'b0;
    @(negedge clk);
    check("prio_lu", 32'(stall_a), 32'h07);
    step();
    lu(1'b0);
    step();

    // jump held under EXE stall: no flush until it leaves EXE
    jump = 1'b1; ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("jstall_flush_a", 32'(flush_a), 32'h0);
      check("jstall_flush_b", 32'(flush_b), 32'h0);
      check("jstall_stall_a", 32'(stall_a), 32'h0f);
      step();
    end
    ex_stall = 1'b0;
    @(negedge clk);
    check("jrel_flush_a", 32'(flush_a), 32'h1);
    check("jrel_flush_b", 32'(flush_b), 32'h1);
    step();
    // multi-cycle flush masks load-use on dut_b only
    jump = 1'b0; lu(1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mf_flush_a", 32'(flush_a), 32'h0);
      check("mf_stall_a", 32'(stall_a), 32'h07);
      check("mf_flush_b", 32'(flush_b), 32'h1);
      check("mf_stall_b", 32'(stall_b), 32'h00);
      step();
    end
    @(negedge clk);
    check("mf_end_flush_b", 32'(flush_b), 32'h0);
    check("mf_end_stall_b", 32'(stall_b), 32'h07);
    step();
    lu(1'b0);
    step();

    // second jump in cycle 2 extends the flush to 4 cycles
    jump = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ext_flush_a_j", 32'(flush_a), 32'h1);
      check("ext_flush_b_j", 32'(flush_b), 32'h1);
      step();
    end
    jump = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ext_flush_a_tail", 32'(flush_a), 32'h0);
      check("ext_flush_b_tail", 32'(flush_b), 32'h1);
      step();
    end
    @(negedge clk);
    check("ext_flush_b_done", 32'(flush_b), 32'h0);
    step();

    // watchdog: 8 stalled cycles set the sticky flag after the 8th edge
    mem_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_pending", 32'(to_a), 32'h0);
      step();
    end
    mem_stall = 1'b0;
    @(negedge clk);
    check("to_set_a", 32'(to_a), 32'h1);
    check("to_set_b", 32'(to_b), 32'h1);
    step();
    step();
    @(negedge clk);
    check("to_sticky", 32'(to_a), 32'h1);

    // reset during FLUSH aborts the flush
    step();
    jump = 1'b1;
    @(negedge clk);
    check("rf_flush_b", 32'(flush_b), 32'h1);
    step();
    jump = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rf_flush_in_rst", 32'(flush_b), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rf_flush_after", 32'(flush_b), 32'h0);
    check("rf_to_a", 32'(to_a), 32'h0);
    check("rf_to_b", 32'(to_b), 32'h0);
    check("rf_stall_cnt", sc_a, 32'd0);
    check("rf_bubble_cnt", bc_a, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
